// File: rtl/reg_file_if.sv
// Register-file port bundle: two combinational read ports, one write port, commit counter.
interface reg_file_if;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] wr_count;

    modport master (
        output rs1_addr, rs2_addr, we, rd_addr, rd_data,
        input  rs1_data, rs2_data, wr_count
    );

    modport slave (
        input  rs1_addr, rs2_addr, we, rd_addr, rd_data,
        output rs1_data, rs2_data, wr_count
    );
endinterface

// File: rtl/reg_file.sv
// RV32I 32x32 register file, x0 hardwired to zero, with committed-write counter.
// Optional RF_BYPASS_EN: write-first forwarding of rd_data onto same-address reads.
module reg_file #(
    parameter logic [31:0] SP_INIT = 32'h0000_0FFC,
    parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);
    logic [31:0] regs_q [1:31];
    logic [31:0] wr_count_q;
    logic [31:0] wr_count_d;
    logic        wr_commit;

    assign wr_commit  = bus.we && (bus.rd_addr != 5'd0);
    assign wr_count_d = wr_commit ? wr_count_q + 32'd1 : wr_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                if (i == 2)      regs_q[i] <= SP_INIT;
                else if (i == 3) regs_q[i] <= GP_INIT;
                else             regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            if (wr_commit) regs_q[bus.rd_addr] <= bus.rd_data;
            wr_count_q <= wr_count_d;
        end
    end

    function automatic logic [31:0] rd_port(input logic [4:0] addr);
        logic [31:0] val;
        val = (addr == 5'd0) ? 32'd0 : regs_q[addr];
`ifdef RF_BYPASS_EN
        // Forward the in-flight write; x0 is excluded by wr_commit.
        if (!rst && wr_commit && (addr == bus.rd_addr)) val = bus.rd_data;
`endif
        return val;
    endfunction

    assign bus.rs1_data = rd_port(bus.rs1_addr);
    assign bus.rs2_data = rd_port(bus.rs2_addr);
    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default parameters).
module tb_reg_file;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    reg_file_if rf();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (rf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.we       = 1'b0;
        rf.rd_addr  = 5'd0;
        rf.rd_data  = 32'd0;
    endtask

    task automatic chk_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        rf.rs1_addr = a;
        rf.rs2_addr = a;
        #1;
        checks++;
        if (rf.rs1_data !== exp) begin
            failures++;
            $display("FAIL %s rs1 x%0d got=%h exp=%h", name, a, rf.rs1_data, exp);
        end
        checks++;
        if (rf.rs2_data !== exp) begin
            failures++;
            $display("FAIL %s rs2 x%0d got=%h exp=%h", name, a, rf.rs2_data, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [31:0] exp);
        checks++;
        if (rf.wr_count !== exp) begin
            failures++;
            $display("FAIL %s wr_count got=%h exp=%h", name, rf.wr_count, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rf.we      = 1'b1;
        rf.rd_addr = a;
        rf.rd_data = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp = (i == 2) ? 32'h0000_0FFC : 32'd0;
            chk_rd("reset", 5'(i), exp);
        end
        chk_cnt("reset", 32'd0);
    endtask

    task automatic test_write();
        wr(5'd5, 32'hDEAD_BEEF);
        chk_rd("write_x5", 5'd5, 32'hDEAD_BEEF);
        chk_cnt("write_x5", 32'd1);
    endtask

    task automatic test_x0();
        wr(5'd0, 32'hFFFF_FFFF);
        chk_rd("write_x0", 5'd0, 32'd0);
        chk_cnt("write_x0", 32'd1);
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_now;
        wr(5'd7, 32'd3);
        chk_cnt("pre_x7", 32'd2);
        rf.rs1_addr = 5'd7;
        rf.rs2_addr = 5'd7;
        rf.we       = 1'b1;
        rf.rd_addr  = 5'd7;
        rf.rd_data  = 32'h0000_001F;
        #1;
`ifdef RF_BYPASS_EN
        exp_now = 32'h0000_001F;
`else
        exp_now = 32'd3;
`endif
        checks++;
        if (rf.rs2_data !== exp_now) begin
            failures++;
            $display("FAIL same_cycle rs2 got=%h exp=%h", rf.rs2_data, exp_now);
        end
        checks++;
        if (rf.rs1_data !== exp_now) begin
            failures++;
            $display("FAIL same_cycle rs1 got=%h exp=%h", rf.rs1_data, exp_now);
        end
        tick();
        idle();
        chk_rd("after_edge_x7", 5'd7, 32'h0000_001F);
        chk_cnt("after_edge_x7", 32'd3);
    endtask

    task automatic test_back_to_back();
        wr(5'd1, 32'h1111_0001);
        wr(5'd2, 32'h2222_0002);
        wr(5'd31, 32'hF00D_CAFE);
        wr(5'd1, 32'hA5A5_5A5A);
        chk_rd("b2b_x1", 5'd1, 32'hA5A5_5A5A);
        chk_rd("b2b_x2", 5'd2, 32'h2222_0002);
        chk_rd("b2b_x31", 5'd31, 32'hF00D_CAFE);
        chk_rd("b2b_x5", 5'd5, 32'hDEAD_BEEF);
        // Independent ports reading different registers.
        rf.rs1_addr = 5'd31;
        rf.rs2_addr = 5'd2;
        #1;
        checks++;
        if (rf.rs1_data !== 32'hF00D_CAFE || rf.rs2_data !== 32'h2222_0002) begin
            failures++;
            $display("FAIL b2b_split got=%h/%h exp=f00dcafe/22220002", rf.rs1_data, rf.rs2_data);
        end
        chk_cnt("b2b", 32'd7);
    endtask

    task automatic test_rst_write();
        rst         = 1'b1;
        rf.we       = 1'b1;
        rf.rd_addr  = 5'd9;
        rf.rd_data  = 32'h0000_1234;
        rf.rs1_addr = 5'd9;
        rf.rs2_addr = 5'd9;
        tick();
        // Still in reset with a write pending: no forwarding, stored value is 0.
        checks++;
        if (rf.rs1_data !== 32'd0) begin
            failures++;
            $display("FAIL rst_fwd rs1 got=%h exp=00000000", rf.rs1_data);
        end
        chk_cnt("rst_held", 32'd0);
        tick();
        rst = 1'b0;
        idle();
        chk_rd("rst_we_x9", 5'd9, 32'd0);
        chk_rd("rst_we_x2", 5'd2, 32'h0000_0FFC);
        chk_rd("rst_we_x5", 5'd5, 32'd0);
        chk_cnt("rst_we", 32'd0);
    endtask

    task automatic test_wrap();
        force dut.wr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_q;
        chk_cnt("preload", 32'hFFFF_FFFF);
        wr(5'd0, 32'h0000_0055);
        chk_cnt("wrap_x0", 32'hFFFF_FFFF);
        wr(5'd10, 32'h0000_0055);
        chk_cnt("wrap", 32'd0);
        chk_rd("wrap_x10", 5'd10, 32'h0000_0055);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        rf.rs1_addr = 5'd0;
        rf.rs2_addr = 5'd0;
        idle();
        tick();
        test_reset();
        test_write();
        test_x0();
        test_same_cycle();
        test_back_to_back();
        test_rst_write();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
